serial_shift_unit: RTL

- Parametrised, multi-cycle shifter that moves a WIDTH-bit word one bit position per clock, for a requested number of positions.
- Supports logical, arithmetic and rotate modes in both directions, with a serial fill input.
- Reports the last bit shifted out (k) and a sticky OR of all bits shifted out.
- Sits between producer and consumer logic behind valid/ready handshakes; next generation of the fixed 4-bit single-step shift-right block.

---
 rtl/serial_shift_unit_pkg.sv | 21 ++
 rtl/serial_shift_unit_step.sv | 50 +++++
 rtl/serial_shift_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_shift_unit_pkg.sv
`default_nettype none
// =====================================================================
// serial_shift_unit_pkg - opcodes and FSM states; rev 1.0
// =====================================================================
package serial_shift_unit_pkg;

  localparam logic [2:0] OP_SRL  = 3'b000;
  localparam logic [2:0] OP_SRA  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_shift_unit_step.sv
`default_nettype none
// =====================================================================
// serial_shift_unit_step - combinational one-position shifter; rev 1.0
// =====================================================================
module serial_shift_unit_step
  import serial_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  input  logic [2:0]       op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_word,
  output logic             out_bit
);

  always_comb begin
    next_word = word;
    out_bit   = 1'b0;
    case (op)
      OP_SRL: begin
        next_word = {ser_in, word[WIDTH-1:1]};
        out_bit   = word[0];
      end
      OP_SRA: begin
        next_word = {word[WIDTH-1], word[WIDTH-1:1]};
        out_bit   = word[0];
      end
      OP_SLL: begin
        next_word = {word[WIDTH-2:0], ser_in};
        out_bit   = word[WIDTH-1];
      end
      OP_ROR: begin
        next_word = {word[0], word[WIDTH-1:1]};
        out_bit   = word[0];
      end
      OP_ROL: begin
        next_word = {word[WIDTH-2:0], word[WIDTH-1]};
        out_bit   = word[WIDTH-1];
      end
      // HOLD and the reserved codes leave the word untouched
      default: begin
        next_word = word;
        out_bit   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_shift_unit.sv
`default_nettype none
// =====================================================================
// serial_shift_unit - one-bit-per-clock shifter with valid/ready; rev 1.0
// =====================================================================
module serial_shift_unit #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  input  logic             ser_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_k,
  output logic             out_sticky,
  output logic             busy
);
  import serial_shift_unit_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             ser_q, ser_d;
  logic             k_q, k_d;
  logic             sticky_q, sticky_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [AMT_W-1:0] amt_eff;
  logic [WIDTH-1:0] step_word;
  logic             step_bit;

  serial_shift_unit_step #(.WIDTH(WIDTH)) u_step (
    .word      (data_q),
    .op        (op_q),
    .ser_in    (ser_q),
    .next_word (step_word),
    .out_bit   (step_bit)
  );

  always_comb begin
    amt_eff = (in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : in_amt;
    if (in_op >= OP_HOLD) amt_eff = '0;
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ser_d    = ser_q;
    k_d      = k_q;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        // ready_q gates the first cycle after reset release
        if (in_valid && ready_q) begin
          data_d   = in_data;
          op_d     = in_op;
          ser_d    = ser_in;
          cnt_d    = amt_eff;
          k_d      = 1'b0;
          sticky_d = 1'b0;
          state_d  = (amt_eff == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d   = step_word;
        k_d      = step_bit;
        sticky_d = sticky_q | step_bit;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d  = S_IDLE;
          data_d   = '0;
          k_d      = 1'b0;
          sticky_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      ser_q    <= 1'b0;
      k_q      <= 1'b0;
      sticky_q <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ser_q    <= ser_d;
      k_q      <= k_d;
      sticky_q <= sticky_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_k      = k_q;
  assign out_sticky = sticky_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
